// File: rtl/birukee_rtl_dma_seq.sv
// ---------------------------------------------------------------------------
// birukee_rtl_dma_seq
// Chunked DMA copy sequencer for the birukee accelerator tile. After a
// conf_done pulse it copies conf_info_input2 32-bit words from word index
// conf_info_input1 to word index conf_info_output. Each chunk of up to CHUNK
// words is read into a local buffer over the DMA read interface and then
// written back out over the DMA write interface. acc_done pulses once the
// whole transfer has been written.
//
// Optional feature macro: BIRUKEE_DMA_SEQ_DBG_EN
//   defined   : debug[31:16] = chunks completed, debug[15:0] = words written
//               (both clear on an accepted conf_done and saturate)
//   undefined : debug is tied to zero and no counter flops exist
//
// State table
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | waiting for conf_done; conf fields are latched on the pulse
//   S_RD_REQ   | read ctrl request (index=src, length=clen) held until ready
//   S_RD_DATA  | accepting clen read beats into the buffer
//   S_WR_REQ   | write ctrl request (index=dst, length=clen) held until ready
//   S_WR_DATA  | streaming clen buffer words out; advances src/dst/rem
//   S_DONE     | acc_done high for this single cycle, then back to idle
// ---------------------------------------------------------------------------
module birukee_rtl_dma_seq #(
   parameter int CHUNK = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] conf_info_input1,
   input  logic [31:0] conf_info_input2,
   input  logic [31:0] conf_info_output,
   input  logic        conf_done,
   output logic        dma_read_ctrl_valid,
   input  logic        dma_read_ctrl_ready,
   output logic [31:0] dma_read_ctrl_data_index,
   output logic [31:0] dma_read_ctrl_data_length,
   output logic [2:0]  dma_read_ctrl_data_size,
   input  logic        dma_read_chnl_valid,
   output logic        dma_read_chnl_ready,
   input  logic [31:0] dma_read_chnl_data,
   output logic        dma_write_ctrl_valid,
   input  logic        dma_write_ctrl_ready,
   output logic [31:0] dma_write_ctrl_data_index,
   output logic [31:0] dma_write_ctrl_data_length,
   output logic [2:0]  dma_write_ctrl_data_size,
   output logic        dma_write_chnl_valid,
   input  logic        dma_write_chnl_ready,
   output logic [31:0] dma_write_chnl_data,
   output logic        acc_done,
   output logic [31:0] debug
);

   // AW addresses the buffer; CW is one bit wider so a pointer can count to CHUNK.
   localparam int AW = (CHUNK > 1) ? $clog2(CHUNK) : 1;
   localparam int CW = AW + 1;
   localparam logic [31:0] CHUNK_W = 32'(CHUNK);
   localparam logic [2:0]  SIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_DATA,
      S_WR_REQ,
      S_WR_DATA,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [31:0]   r_src;
   logic [31:0]   r_dst;
   logic [31:0]   r_rem;
   logic [31:0]   r_clen;
   logic [CW-1:0] r_wptr;
   logic [CW-1:0] r_rptr;
   logic [31:0]   r_buf [CHUNK];

   logic          r_rd_ctrl_valid;
   logic [31:0]   r_rd_idx;
   logic [31:0]   r_rd_len;
   logic          r_rd_chnl_ready;
   logic          r_wr_ctrl_valid;
   logic [31:0]   r_wr_idx;
   logic [31:0]   r_wr_len;
   logic          r_wr_chnl_valid;
   logic [31:0]   r_wr_data;
   logic          r_acc_done;

   logic          w_rd_beat;
   logic          w_wr_beat;
   logic [CW-1:0] w_wptr_nxt;
   logic [CW-1:0] w_rptr_nxt;
   logic          w_rd_last;
   logic          w_wr_last;
   logic [31:0]   w_src_nxt;
   logic [31:0]   w_dst_nxt;
   logic [31:0]   w_rem_nxt;
   logic [31:0]   w_clen_conf;
   logic [31:0]   w_clen_nxt;

   // Burst length for the next chunk: whatever is left, capped at the buffer depth.
   function automatic logic [31:0] f_clen(input logic [31:0] rem);
      return (rem > CHUNK_W) ? CHUNK_W : rem;
   endfunction

   // The ready/valid registers are only high in their own states, so a beat is
   // simply the AND of our registered side and the peer's side.
   assign w_rd_beat   = r_rd_chnl_ready & dma_read_chnl_valid;
   assign w_wr_beat   = r_wr_chnl_valid & dma_write_chnl_ready;
   assign w_wptr_nxt  = r_wptr + CW'(1);
   assign w_rptr_nxt  = r_rptr + CW'(1);
   assign w_rd_last   = w_rd_beat && (32'(w_wptr_nxt) == r_clen);
   assign w_wr_last   = w_wr_beat && (32'(w_rptr_nxt) == r_clen);
   assign w_src_nxt   = r_src + r_clen;
   assign w_dst_nxt   = r_dst + r_clen;
   assign w_rem_nxt   = r_rem - r_clen;
   assign w_clen_conf = f_clen(conf_info_input2);
   assign w_clen_nxt  = f_clen(w_rem_nxt);

   // Sequencer FSM with all handshake and data outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= S_IDLE;
         r_src           <= '0;
         r_dst           <= '0;
         r_rem           <= '0;
         r_clen          <= '0;
         r_wptr          <= '0;
         r_rptr          <= '0;
         r_rd_ctrl_valid <= 1'b0;
         r_rd_idx        <= '0;
         r_rd_len        <= '0;
         r_rd_chnl_ready <= 1'b0;
         r_wr_ctrl_valid <= 1'b0;
         r_wr_idx        <= '0;
         r_wr_len        <= '0;
         r_wr_chnl_valid <= 1'b0;
         r_wr_data       <= '0;
         r_acc_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (conf_done) begin
                  r_src  <= conf_info_input1;
                  r_dst  <= conf_info_output;
                  r_rem  <= conf_info_input2;
                  r_wptr <= '0;
                  r_rptr <= '0;
                  if (conf_info_input2 == 32'd0) begin
                     r_acc_done <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_clen          <= w_clen_conf;
                     r_rd_ctrl_valid <= 1'b1;
                     r_rd_idx        <= conf_info_input1;
                     r_rd_len        <= w_clen_conf;
                     r_state         <= S_RD_REQ;
                  end
               end
            end
            S_RD_REQ: begin
               if (dma_read_ctrl_ready) begin
                  r_rd_ctrl_valid <= 1'b0;
                  r_rd_chnl_ready <= 1'b1;
                  r_state         <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (w_rd_beat) begin
                  r_wptr <= w_wptr_nxt;
                  if (w_rd_last) begin
                     r_rd_chnl_ready <= 1'b0;
                     r_wr_ctrl_valid <= 1'b1;
                     r_wr_idx        <= r_dst;
                     r_wr_len        <= r_clen;
                     r_state         <= S_WR_REQ;
                  end
               end
            end
            S_WR_REQ: begin
               if (dma_write_ctrl_ready) begin
                  r_wr_ctrl_valid <= 1'b0;
                  r_wr_chnl_valid <= 1'b1;
                  r_wr_data       <= r_buf[AW'(0)];
                  r_state         <= S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (w_wr_beat) begin
                  r_rptr <= w_rptr_nxt;
                  if (!w_wr_last) begin
                     // Prefetch the next word so data stays registered and
                     // one beat per cycle is sustained.
                     r_wr_data <= r_buf[w_rptr_nxt[AW-1:0]];
                  end else begin
                     r_wr_chnl_valid <= 1'b0;
                     r_src           <= w_src_nxt;
                     r_dst           <= w_dst_nxt;
                     r_rem           <= w_rem_nxt;
                     r_wptr          <= '0;
                     r_rptr          <= '0;
                     if (w_rem_nxt != 32'd0) begin
                        r_clen          <= w_clen_nxt;
                        r_rd_ctrl_valid <= 1'b1;
                        r_rd_idx        <= w_src_nxt;
                        r_rd_len        <= w_clen_nxt;
                        r_state         <= S_RD_REQ;
                     end else begin
                        r_acc_done <= 1'b1;
                        r_state    <= S_DONE;
                     end
                  end
               end
            end
            S_DONE: begin
               r_acc_done <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Chunk buffer; contents are don't-care after reset so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_rd_beat) begin
         r_buf[r_wptr[AW-1:0]] <= dma_read_chnl_data;
      end
   end

`ifdef BIRUKEE_DMA_SEQ_DBG_EN
   logic [15:0] r_dbg_chunks;
   logic [15:0] r_dbg_words;

   // Saturating progress counters, restarted by each accepted conf_done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dbg_chunks <= '0;
         r_dbg_words  <= '0;
      end else if ((r_state == S_IDLE) && conf_done) begin
         r_dbg_chunks <= '0;
         r_dbg_words  <= '0;
      end else if (w_wr_beat) begin
         if (r_dbg_words != 16'hFFFF) begin
            r_dbg_words <= r_dbg_words + 16'd1;
         end
         if (w_wr_last && (r_dbg_chunks != 16'hFFFF)) begin
            r_dbg_chunks <= r_dbg_chunks + 16'd1;
         end
      end
   end

   assign debug = {r_dbg_chunks, r_dbg_words};
`else
   assign debug = 32'd0;
`endif

   assign dma_read_ctrl_valid        = r_rd_ctrl_valid;
   assign dma_read_ctrl_data_index   = r_rd_idx;
   assign dma_read_ctrl_data_length  = r_rd_len;
   assign dma_read_ctrl_data_size    = SIZE_WORD;
   assign dma_read_chnl_ready        = r_rd_chnl_ready;
   assign dma_write_ctrl_valid       = r_wr_ctrl_valid;
   assign dma_write_ctrl_data_index  = r_wr_idx;
   assign dma_write_ctrl_data_length = r_wr_len;
   assign dma_write_ctrl_data_size   = SIZE_WORD;
   assign dma_write_chnl_valid       = r_wr_chnl_valid;
   assign dma_write_chnl_data        = r_wr_data;
   assign acc_done                   = r_acc_done;

endmodule
